// File: rtl/mm_ln_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : mm_ln_pkg                                                    |
// | Purpose   : Shared constants and types for the LayerNorm/matmul          |
// |             parameter path: segment count, length width, segment        |
// |             index names and the transmit FSM state encoding.             |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package mm_ln_pkg;

  localparam int NUM_SEG   = 9;
  localparam int LEN_W     = 24;
  localparam int SEG_IDX_W = $clog2(NUM_SEG);

  // Frame order of the parameter segments.
  typedef enum logic [SEG_IDX_W-1:0] {
    SEG_W       = 4'd0,
    SEG_R_M     = 4'd1,
    SEG_R_E     = 4'd2,
    SEG_W_BIAS  = 4'd3,
    SEG_W_M     = 4'd4,
    SEG_W_E     = 4'd5,
    SEG_LN_BIAS = 4'd6,
    SEG_OUT_M   = 4'd7,
    SEG_OUT_E   = 4'd8
  } seg_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_SEND  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mm_ln_param_tx_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : axis_skid_buf                                                |
// | Purpose   : Two-entry AXI-Stream register slice. The upstream ready is   |
// |             driven from a flop only, so no combinational path exists    |
// |             from out_ready to in_ready. Full throughput with            |
// |             out_ready held high; one cycle of latency.                   |
// | Ports     : clk, rst_n (sync, active-low)                                |
// |             in_data/in_valid/in_ready   - upstream side                 |
// |             out_data/out_valid/out_ready - downstream side              |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module axis_skid_buf #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] main_d;
  logic [W-1:0] skid_d;
  logic         main_v;
  logic         skid_v;
  logic         in_fire;

  // Ready only depends on the skid entry being empty.
  assign in_ready  = ~skid_v;
  assign in_fire   = in_valid & in_ready;
  assign out_data  = main_d;
  assign out_valid = main_v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_d <= '0;
      skid_d <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      // Output register is free to move: refill from skid first, else input.
      if (skid_v) begin
        main_d <= skid_d;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= in_fire;
        if (in_fire) begin
          main_d <= in_data;
        end
      end
    end else if (in_fire) begin
      // Downstream stalled while a beat was already accepted: park it.
      skid_d <= in_data;
      skid_v <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mm_ln_param_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : mm_ln_param_tx                                               |
// | Purpose   : Serialises NUM_SEG parameter streams into one 32-bit         |
// |             AXI-Stream frame in segment order, with per-segment TLAST   |
// |             and an end-of-frame FLAST derived from seg_len.             |
// | Ports     : clk, rst_n (sync, active-low)                                |
// |             seg_len  - packed per-segment beat counts, latched on start |
// |             start    - frame start pulse (ignored while busy)           |
// |             s_T*     - per-segment source streams                       |
// |             m_T*     - serialised output stream, m_FLAST on final beat  |
// |             busy, frame_done, len_err                                   |
// | Options   : define MM_LN_PARAM_TX_LEN_CHECK_EN to compare source TLAST   |
// |             against the length-derived last beat (sticky len_err).      |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module mm_ln_param_tx
  import mm_ln_pkg::*;
#(
  parameter int D_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SEG*LEN_W-1:0] seg_len,
  input  logic                     start,
  input  logic [NUM_SEG*D_W-1:0]   s_TDATA,
  input  logic [NUM_SEG-1:0]       s_TVALID,
  output logic [NUM_SEG-1:0]       s_TREADY,
  input  logic [NUM_SEG-1:0]       s_TLAST,
  output logic [D_W-1:0]           m_TDATA,
  output logic                     m_TVALID,
  input  logic                     m_TREADY,
  output logic                     m_TLAST,
  output logic                     m_FLAST,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     len_err
);

  state_t                 state;
  state_t                 state_nxt;
  logic [LEN_W-1:0]       len_r [NUM_SEG];
  logic [SEG_IDX_W-1:0]   seg_idx;
  logic [LEN_W-1:0]       beat_cnt;
  logic                   frame_done_r;

  logic [NUM_SEG-1:0]     len_nz;
  logic [SEG_IDX_W-1:0]   first_nz;
  logic [SEG_IDX_W-1:0]   next_nz;
  logic                   any_nz;
  logic                   has_next;

  logic [LEN_W-1:0]       cur_len;
  logic [D_W-1:0]         cur_data;
  logic                   cur_valid;
  logic                   seg_last;
  logic                   src_fire;
  logic                   start_ok;
  logic                   out_fire;

  logic                   slice_valid;
  logic                   slice_ready;

  // ---------------------------------------------------------------------
  // Current-segment selection and next-nonzero-segment search
  // ---------------------------------------------------------------------
  always_comb begin
    cur_len   = '0;
    cur_data  = '0;
    cur_valid = 1'b0;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (seg_idx == SEG_IDX_W'(k)) begin
        cur_len   = len_r[k];
        cur_data  = s_TDATA[k*D_W +: D_W];
        cur_valid = s_TVALID[k];
      end
    end
  end

  // Descending scans so the lowest matching index wins.
  always_comb begin
    len_nz   = '0;
    first_nz = '0;
    any_nz   = 1'b0;
    next_nz  = '0;
    has_next = 1'b0;
    for (int k = NUM_SEG - 1; k >= 0; k--) begin
      len_nz[k] = |len_r[k];
      if (len_nz[k]) begin
        first_nz = SEG_IDX_W'(k);
        any_nz   = 1'b1;
      end
      if (len_nz[k] && (SEG_IDX_W'(k) > seg_idx)) begin
        next_nz  = SEG_IDX_W'(k);
        has_next = 1'b1;
      end
    end
  end

  assign seg_last = (beat_cnt == (cur_len - LEN_W'(1)));
  assign src_fire = (state == ST_SEND) && cur_valid && slice_ready;
  assign out_fire = m_TVALID && m_TREADY;
  // A start coinciding with the frame_done pulse belongs to the old frame.
  assign start_ok = start && !frame_done_r;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = any_nz ? ST_SEND : ST_IDLE;
      ST_SEND:  if (src_fire && seg_last && !has_next) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_fire && m_FLAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    s_TREADY    = '0;
    slice_valid = 1'b0;
    busy        = (state != ST_IDLE) || frame_done_r;
    if (state == ST_SEND) begin
      slice_valid = cur_valid;
      for (int k = 0; k < NUM_SEG; k++) begin
        if (seg_idx == SEG_IDX_W'(k)) begin
          s_TREADY[k] = slice_ready;
        end
      end
    end
  end

  assign frame_done = frame_done_r;

  // ---------------------------------------------------------------------
  // Frame bookkeeping: lengths, segment pointer, beat counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SEG; k++) begin
        len_r[k] <= '0;
      end
      seg_idx      <= SEG_IDX_W'(SEG_W);
      beat_cnt     <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= ((state == ST_LOAD) && !any_nz) ||
                      ((state == ST_DRAIN) && out_fire && m_FLAST);
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            for (int k = 0; k < NUM_SEG; k++) begin
              len_r[k] <= seg_len[k*LEN_W +: LEN_W];
            end
            seg_idx  <= SEG_IDX_W'(SEG_W);
            beat_cnt <= '0;
          end
        end
        ST_LOAD: seg_idx <= first_nz;
        ST_SEND: begin
          if (src_fire) begin
            if (seg_last) begin
              beat_cnt <= '0;
              if (has_next) begin
                seg_idx <= next_nz;
              end
            end else begin
              beat_cnt <= beat_cnt + LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output register slice: payload = {FLAST, TLAST, DATA}
  // ---------------------------------------------------------------------
  axis_skid_buf #(
    .W (D_W + 2)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({seg_last && !has_next, seg_last, cur_data}),
    .in_valid  (slice_valid),
    .in_ready  (slice_ready),
    .out_data  ({m_FLAST, m_TLAST, m_TDATA}),
    .out_valid (m_TVALID),
    .out_ready (m_TREADY)
  );

  // ---------------------------------------------------------------------
  // Optional source-TLAST consistency check
  // ---------------------------------------------------------------------
`ifdef MM_LN_PARAM_TX_LEN_CHECK_EN
  logic cur_tlast;
  logic len_err_r;

  always_comb begin
    cur_tlast = 1'b0;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (seg_idx == SEG_IDX_W'(k)) begin
        cur_tlast = s_TLAST[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_err_r <= 1'b0;
    end else if (src_fire && (cur_tlast != seg_last)) begin
      len_err_r <= 1'b1;
    end
  end

  assign len_err = len_err_r;
`else
  // Source TLAST has no role in framing when the check is not built.
  logic unused_tlast;
  assign unused_tlast = ^s_TLAST;
  assign len_err      = 1'b0;
`endif

endmodule
`default_nettype wire
